// File: rtl/vram_pkg.sv
// Shared constants and encodings for the VRAM write-port controller and its tile walker.
package vram_pkg;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int TILE   = 32;
  localparam int ADDR_W = 18;
  localparam int PIX_W  = 12;

  localparam logic [PIX_W-1:0] KEY_COLOR = 12'hF0F;

  typedef enum logic [1:0] {
    SRC_BG   = 2'd0,
    SRC_CHAR = 2'd1,
    SRC_CI   = 2'd2,
    SRC_WALL = 2'd3
  } src_e;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BLIT = 1'b1
  } state_e;

endpackage

// File: rtl/vram_blit_walker.sv
// Tile walker: px/py/row_base counters, framebuffer clip test and last-pixel flag.
module vram_blit_walker
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [8:0]        x_in,
  input  logic [7:0]        y_in,
  output logic [4:0]        px,
  output logic [4:0]        py,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              in_bounds,
  output logic              last
);

  logic [8:0]        x0;
  logic [7:0]        y0;
  logic [ADDR_W-1:0] row_base;
  logic [9:0]        col;
  logic [8:0]        row;

  always_ff @(posedge clk) begin
    if (rst) begin
      x0       <= '0;
      y0       <= '0;
      px       <= '0;
      py       <= '0;
      row_base <= '0;
    end else if (load) begin
      x0       <= x_in;
      y0       <= y_in;
      px       <= '0;
      py       <= '0;
      row_base <= ADDR_W'(y_in) * ADDR_W'(FB_W) + ADDR_W'(x_in);
    end else if (step) begin
      px <= px + 5'd1;
      if (px == 5'(TILE - 1)) begin
        py       <= py + 5'd1;
        row_base <= row_base + ADDR_W'(FB_W);
      end
    end
  end

  // Widened sums so an off-screen origin never wraps back into range.
  assign col       = {1'b0, x0} + 10'(px);
  assign row       = {1'b0, y0} + 9'(py);
  assign in_bounds = (col < 10'(FB_W)) && (row < 9'(FB_H));
  assign last      = (px == 5'(TILE - 1)) && (py == 5'(TILE - 1));
  assign pix_addr  = row_base + ADDR_W'(px);

endmodule

// File: rtl/vram_blit_ctrl.sv
// VRAM port-A owner: CPU pixel writes take priority over a 32x32 copy/fill blitter.
// Build option: define TRANSPARENT_KEY_EN to skip KEY_COLOR pixels during ROM copies.
module vram_blit_ctrl
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [1:0]        cmd_src,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [PIX_W-1:0]  cmd_color,
  output logic [1:0]        rom_sel,
  output logic [9:0]        rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [PIX_W-1:0]  vram_data,
  output logic              busy,
  output logic              done
);

  state_e            state;
  op_e               op_q;
  src_e              src_q;
  logic [PIX_W-1:0]  color_q;
  logic              load;
  logic              step;
  logic [4:0]        px;
  logic [4:0]        py;
  logic [ADDR_W-1:0] pix_addr;
  logic              in_bounds;
  logic              last;
  logic              key_hit;
  logic [PIX_W-1:0]  pix_data;

  assign load      = (state == ST_IDLE) && cmd_valid;
  assign step      = (state == ST_BLIT) && !cpu_we;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_BLIT);
  assign rom_sel   = src_q;
  assign rom_addr  = {py, px};
  assign pix_data  = (op_q == OP_FILL) ? color_q : rom_data;

`ifdef TRANSPARENT_KEY_EN
  assign key_hit = (op_q == OP_COPY) && (rom_data == KEY_COLOR);
`else
  assign key_hit = 1'b0;
`endif

  vram_blit_walker u_walker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .x_in      (cmd_x),
    .y_in      (cmd_y),
    .px        (px),
    .py        (py),
    .pix_addr  (pix_addr),
    .in_bounds (in_bounds),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_COPY;
      src_q     <= SRC_BG;
      color_q   <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
      done      <= 1'b0;
    end else begin
      vram_we <= 1'b0;
      done    <= 1'b0;
      // Clipped or keyed pixels still consume their step, only the write is dropped.
      if (cpu_we) begin
        vram_we   <= 1'b1;
        vram_addr <= cpu_addr;
        vram_data <= cpu_data;
      end else if (step && in_bounds && !key_hit) begin
        vram_we   <= 1'b1;
        vram_addr <= pix_addr;
        vram_data <= pix_data;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= op_e'(cmd_op);
            src_q   <= src_e'(cmd_src);
            color_q <= cmd_color;
            state   <= ST_BLIT;
          end
        end
        ST_BLIT: begin
          if (step && last) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vram_blit_ctrl.md
Name: vram_blit_ctrl

Overview:
Owns the single VRAM write port (port A, 18-bit address, 12-bit pixel). Arbitrates it between direct CPU pixel writes from the memory-mapped I/O bus and a tile blitter. The blitter copies a 32x32 tile from one of the four sprite ROMs (background, character, ci, wall), or fills a 32x32 rectangle with a constant colour. The VRAM read side (GPU/VGA) is untouched; the CPU has strict priority over the blitter.

Parameters:
FB_W, 320, framebuffer width in pixels; linear VRAM address = row*FB_W + col
FB_H, 240, framebuffer height in pixels
TILE, 32, tile edge in pixels; TILE*TILE = 1024 = ROM depth
KEY_COLOR, 12'hF0F, transparent colour (used only with optional feature)

Ports:
clk  in  1  system clock (clk_100mhz domain)
rst  in  1  synchronous, active-high reset
cpu_we  in  1  CPU pixel write strobe, one pixel per cycle
cpu_addr  in  18  CPU pixel address
cpu_data  in  12  CPU pixel colour
cmd_valid  in  1  blit command valid
cmd_ready  out  1  high in IDLE only
cmd_op  in  1  0 = copy from ROM, 1 = fill
cmd_src  in  2  ROM select: 0 background, 1 character, 2 ci, 3 wall
cmd_x  in  9  destination top-left column
cmd_y  in  8  destination top-left row
cmd_color  in  12  fill colour (op=1)
rom_sel  out  2  ROM select to external mux
rom_addr  out  10  ROM word address = py*TILE + px
rom_data  in  12  combinational ROM data (distributed ROM, same cycle)
vram_we  out  1  registered VRAM write enable
vram_addr  out  18  registered VRAM write address
vram_data  out  12  registered VRAM write data
busy  out  1  high in BLIT
done  out  1  one-cycle pulse when the last tile pixel is processed

Behaviour:
- Reset: state IDLE; vram_we=0, vram_addr=0, vram_data=0, busy=0, done=0, rom_sel=0, rom_addr=0, counters 0. Reset mid-blit aborts immediately; no further writes.
- States:
  - IDLE: cmd_ready=1. cmd_valid sampled high latches op/src/color and sets row_base = cmd_y*FB_W + cmd_x (constant multiply). Also latches x0/y0, clears px/py and moves to BLIT.
  - BLIT: cmd_ready=0; cmd_valid is ignored and held by the requester. Each free cycle processes pixel (px,py) and advances px; px wrap 31->0 increments py and adds FB_W to row_base. After px=31,py=31 is processed: done=1 for that cycle's edge and state returns to IDLE.
- Arbitration, per cycle:
  - cpu_we=1: next edge registers vram_we=1, vram_addr=cpu_addr, vram_data=cpu_data. The blitter holds px/py/row_base (stall).
  - Otherwise, in BLIT: pixel is writable if x0+px < FB_W and y0+py < FB_H (compared at 10/9 bits, no wrap). Writable pixel: vram_we=1, vram_addr=row_base+px, vram_data = rom_data (op=0) or color (op=1). Clipped pixel: vram_we=0 but the counter still advances.
  - Otherwise: vram_we=0; vram_addr/data hold their last values.
- Latency:
  - CPU write reaches the port 1 cycle after cpu_we.
  - Blit: first pixel is registered at the edge after acceptance. An uncontended blit takes exactly 1024 cycles regardless of clipping; each CPU write cycle adds 1.
- rom_sel/rom_addr are combinational from latched src and px/py; valid throughout BLIT.
- done and cmd_valid in the same cycle: the command is not accepted until the cycle after done (IDLE).

Optional Feature:
TRANSPARENT_KEY_EN
- Defined: in op=0 only, pixels with rom_data == KEY_COLOR are treated as clipped (no write, counter advances). Fill ignores the key.
- Undefined: every in-bounds pixel is written; KEY_COLOR unused.

Decomposition:
- Shared package vram_pkg: FB_W, FB_H, TILE, VRAM address width 18, pixel width 12, ROM select encodings (SRC_BG, SRC_CHAR, SRC_CI, SRC_WALL), op encodings (OP_COPY, OP_FILL), state encoding.
- One natural sub-module: vram_blit_walker. It holds the px/py/row_base counters, clip compare and last-pixel flag, and takes step/load inputs. Arbitration, FSM and output registers stay in the top.

Test Plan:
1. Copy, src=1, (0,0), ROM returns rom_addr, no CPU activity -> 1024 consecutive writes; addr = py*320+px, data = py*32+px; done exactly 1024 cycles after accept; rom_sel=1 throughout.
2. Copy at (64,10), CPU writes 0xABC to 0x12345 for 5 cycles starting at blit cycle 100 -> those 5 writes appear unchanged; blit lasts 1029 cycles; all 1024 tile pixels written once, none duplicated.
3. Clip: copy at (300,220) -> exactly 400 writes (20x20); last addr 239*320+319 = 76799; done still at cycle 1024.
4. Fill, color 0x0F0, at (32,32) -> 1024 writes of 0x0F0; first addr 32*320+32 = 10272; last addr 63*320+63 = 20223.
5. rst asserted at blit cycle 500 -> next edge: vram_we=0, busy=0, cmd_ready=1; no further writes; a new command is then accepted normally.
6. TRANSPARENT_KEY_EN defined, ROM returns 0xF0F for even px, otherwise 0x123 -> 512 writes, all odd columns; without the macro -> 1024 writes.
